psx_controller_frame: RTL and testbench

Frame engine for the PSX pad link, sitting directly around `psx_controller_clk_gen`. It accepts a poll request, drops ATT and starts the clock generator with `gen`. It then shifts the poll command out on CMD and samples DATA on the generated `c_clk` edges. On frame completion it validates the reply and publishes decoded button (and optionally analog) state to game logic.

---
 rtl/psx_controller_frame_pkg.sv | 31 +++
 rtl/psx_byte_shifter.sv | 70 +++++++
 rtl/psx_controller_frame.sv | 178 +++++++++++++++++
 tb/tb_psx_controller_frame.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/psx_controller_frame_pkg.sv
// Shared definitions for the PSX pad frame engine: FSM states, command bytes, reply marker, frame lengths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package psx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_XFER  = 3'd2,
        ST_CHECK = 3'd3,
        ST_HOLD  = 3'd4
    } state_e;

    localparam logic [7:0] CMD_START = 8'h01;
    localparam logic [7:0] CMD_POLL  = 8'h42;
    localparam logic [7:0] CMD_IDLE  = 8'h00;
    localparam logic [7:0] ACK_MARK  = 8'h5A;

    localparam logic [3:0] DIGITAL_BYTES = 4'd5;
    localparam logic [3:0] ANALOG_BYTES  = 4'd9;

    // Command byte sent at a given frame index; wide index so a saturated count never wraps to 0.
    function automatic logic [7:0] cmd_byte(input logic [4:0] idx);
        case (idx)
            5'd0:    return CMD_START;
            5'd1:    return CMD_POLL;
            default: return CMD_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/psx_byte_shifter.sv
// Pad bit engine: c_clk edge detect, CMD shift-out on falling edges, DATA shift-in (LSB first) on rising edges.
// Latency: cmd updates one cycle after a falling edge is seen; byte_done pulses one cycle after the 8th rising edge.
// Backpressure: none; paced entirely by c_clk, idle (cmd=1, counters cleared) whenever en is low.
module psx_byte_shifter
    import psx_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       c_clk,
    input  logic       dat,
    input  logic [7:0] tx_next,
    output logic       cmd,
    output logic       byte_done,
    output logic [7:0] rx_byte
);

    logic       c_clk_q;
    logic       dat_q;
    logic [7:0] tx_sr_q;
    logic [7:0] rx_sr_q;
    logic [2:0] bit_cnt_q;
    logic       cmd_q;
    logic       done_q;
    logic       fall;
    logic       rise;

    assign fall = en &  c_clk_q & ~c_clk;
    assign rise = en & ~c_clk_q &  c_clk;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_clk_q   <= 1'b1;
            dat_q     <= 1'b1;
            tx_sr_q   <= CMD_START;
            rx_sr_q   <= '0;
            bit_cnt_q <= '0;
            cmd_q     <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            c_clk_q <= c_clk;
            dat_q   <= dat;
            done_q  <= 1'b0;
            if (!en) begin
                // Parked with the first command byte so entry into a transfer starts cleanly.
                tx_sr_q   <= CMD_START;
                bit_cnt_q <= '0;
                cmd_q     <= 1'b1;
            end else if (fall) begin
                cmd_q   <= tx_sr_q[0];
                tx_sr_q <= {1'b0, tx_sr_q[7:1]};
            end else if (rise) begin
                rx_sr_q <= {dat_q, rx_sr_q[7:1]};
                if (bit_cnt_q == 3'd7) begin
                    bit_cnt_q <= '0;
                    done_q    <= 1'b1;
                    tx_sr_q   <= tx_next;
                    cmd_q     <= 1'b1;
                end else begin
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                end
            end
        end
    end

    assign cmd       = cmd_q;
    assign byte_done = done_q;
    assign rx_byte   = rx_sr_q;

endmodule

// File: rtl/psx_controller_frame.sv
// PSX pad frame engine (PSX_ANALOG_EN adds the 9-byte analog reply): poll -> ATT low -> gen -> shift -> validate -> publish.
// Latency: gen ATT_SETUP cycles after att_n falls; valid/bad_frame one cycle after the frame check.
// Backpressure: polls outside IDLE are dropped, never queued; HOLDOFF cycles of ATT high separate frames.
module psx_controller_frame
    import psx_pkg::*;
#(
    parameter int unsigned ATT_SETUP = 4,
    parameter int unsigned HOLDOFF   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        poll,
    input  logic        c_clk,
    input  logic        ready,
    input  logic        err,
    input  logic        dat,
    output logic        gen,
    output logic [3:0]  bytes_expected,
    output logic        att_n,
    output logic        cmd,
    output logic        busy,
    output logic [15:0] buttons,
    output logic [7:0]  pad_id,
    output logic [31:0] analog,
    output logic        valid,
    output logic        bad_frame
);

`ifdef PSX_ANALOG_EN
    localparam logic [3:0] BYTES_EXP = ANALOG_BYTES;
`else
    localparam logic [3:0] BYTES_EXP = DIGITAL_BYTES;
`endif
    localparam int unsigned BUF_N = int'(BYTES_EXP);
    localparam int unsigned CNT_W = 8;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               gen_q, gen_d;
    logic               valid_q, valid_d;
    logic               bad_q, bad_d;
    logic [3:0]         byte_cnt_q;
    logic [7:0]         rx_buf_q [BUF_N];
    logic [15:0]        buttons_q;
    logic [7:0]         pad_id_q;
    logic               byte_clr;
    logic               accept;
    logic               byte_done;
    logic [7:0]         rx_byte;
    logic [7:0]         tx_next;
    logic               xfer_en;

    assign xfer_en = (state_q == ST_XFER);
    // The shifter loads the next command while byte_cnt still names the byte just finished.
    assign tx_next = cmd_byte({1'b0, byte_cnt_q} + 5'd1);
    assign accept  = (rx_buf_q[2] == ACK_MARK) && (byte_cnt_q >= BYTES_EXP);

    psx_byte_shifter u_shifter (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (xfer_en),
        .c_clk     (c_clk),
        .dat       (dat),
        .tx_next   (tx_next),
        .cmd       (cmd),
        .byte_done (byte_done),
        .rx_byte   (rx_byte)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        gen_d    = 1'b0;
        valid_d  = 1'b0;
        bad_d    = 1'b0;
        byte_clr = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (poll) state_d = ST_SETUP;
            end
            ST_SETUP: begin
                if (cnt_q == CNT_W'(ATT_SETUP - 1)) begin
                    state_d  = ST_XFER;
                    cnt_d    = '0;
                    gen_d    = 1'b1;
                    byte_clr = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_XFER: begin
                if (err) begin
                    state_d = ST_HOLD;
                    bad_d   = 1'b1;
                end else if (ready) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                state_d = ST_HOLD;
                valid_d = accept;
                bad_d   = !accept;
            end
            ST_HOLD: begin
                if (cnt_q == CNT_W'(HOLDOFF - 1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            gen_q      <= 1'b0;
            valid_q    <= 1'b0;
            bad_q      <= 1'b0;
            byte_cnt_q <= '0;
            buttons_q  <= '0;
            pad_id_q   <= '0;
            for (int i = 0; i < BUF_N; i++) rx_buf_q[i] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gen_q   <= gen_d;
            valid_q <= valid_d;
            bad_q   <= bad_d;
            if (byte_clr) begin
                byte_cnt_q <= '0;
            end else if (byte_done) begin
                // Bytes past the expected length are counted but not stored.
                for (int i = 0; i < BUF_N; i++) begin
                    if (byte_cnt_q == 4'(i)) rx_buf_q[i] <= rx_byte;
                end
                if (byte_cnt_q != 4'hF) byte_cnt_q <= byte_cnt_q + 4'd1;
            end
            if (valid_d) begin
                buttons_q <= ~{rx_buf_q[4], rx_buf_q[3]};
                pad_id_q  <= rx_buf_q[1];
            end
        end
    end

`ifdef PSX_ANALOG_EN
    logic [31:0] analog_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            analog_q <= '0;
        end else if (valid_d) begin
            analog_q <= {rx_buf_q[8], rx_buf_q[7], rx_buf_q[6], rx_buf_q[5]};
        end
    end

    assign analog = analog_q;
`else
    assign analog = '0;
`endif

    assign att_n          = !(state_q inside {ST_SETUP, ST_XFER, ST_CHECK});
    assign busy           = (state_q != ST_IDLE);
    assign gen            = gen_q;
    assign bytes_expected = BYTES_EXP;
    assign buttons        = buttons_q;
    assign pad_id         = pad_id_q;
    assign valid          = valid_q;
    assign bad_frame      = bad_q;

endmodule

// File: tb/tb_psx_controller_frame.sv
// Bench for psx_controller_frame: pad/clock-generator model drives frames, a reference model predicts each outcome.
module tb_psx_controller_frame;

`ifdef PSX_ANALOG_EN
    localparam int BE  = 9;
    localparam bit AEN = 1'b1;
`else
    localparam int BE  = 5;
    localparam bit AEN = 1'b0;
`endif
    localparam int T_ATT  = 4;
    localparam int T_HOLD = 8;
    localparam int HALF   = 4;

    typedef logic [7:0] frame_t [16];
    typedef struct {
        bit          good;
        logic [15:0] b;
        logic [7:0]  id;
        logic [31:0] an;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        poll = 1'b0;
    logic        c_clk = 1'b1;
    logic        ready = 1'b0;
    logic        err = 1'b0;
    logic        dat = 1'b1;
    logic        gen, att_n, cmd, busy, valid, bad_frame;
    logic [3:0]  bytes_expected;
    logic [15:0] buttons;
    logic [7:0]  pad_id;
    logic [31:0] analog;

    int errors = 0;
    int checks = 0;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [15:0] m_b  = '0;
    logic [7:0]  m_id = '0;
    logic [31:0] m_an = '0;

    psx_controller_frame dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .poll           (poll),
        .c_clk          (c_clk),
        .ready          (ready),
        .err            (err),
        .dat            (dat),
        .gen            (gen),
        .bytes_expected (bytes_expected),
        .att_n          (att_n),
        .cmd            (cmd),
        .busy           (busy),
        .buttons        (buttons),
        .pad_id         (pad_id),
        .analog         (analog),
        .valid          (valid),
        .bad_frame      (bad_frame)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] exp_cmd(input int idx);
        if (idx == 0) return 8'h01;
        if (idx == 1) return 8'h42;
        return 8'h00;
    endfunction

    // Reference: a frame is published only if it completed, was long enough and carries 5A at byte 2.
    task automatic predict(input frame_t r, input int n, input bit aborted);
        exp_t e;
        e.good = (!aborted && n >= BE && r[2] == 8'h5A);
        if (e.good) begin
            m_b  = ~{r[4], r[3]};
            m_id = r[1];
            if (AEN) m_an = {r[8], r[7], r[6], r[5]};
        end
        e.b  = m_b;
        e.id = m_id;
        e.an = m_an;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (rst_n && (valid || bad_frame)) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: valid=%b bad_frame=%b with no frame outstanding", valid, bad_frame);
            end else begin
                mon_e = sb.pop_front();
                check("valid", valid, mon_e.good);
                check("bad_frame", bad_frame, !mon_e.good);
                check("buttons", buttons, mon_e.b);
                check("pad_id", pad_id, mon_e.id);
                check("analog", analog, mon_e.an);
            end
        end
    end

    task automatic send_byte(input logic [7:0] d, input int nbits, output logic [7:0] cb);
        cb = '0;
        for (int i = 0; i < nbits; i++) begin
            c_clk = 1'b0;
            dat   = d[i];
            repeat (HALF) @(posedge clk);
            #1;
            cb[i] = cmd;
            c_clk = 1'b1;
            repeat (HALF) @(posedge clk);
            #1;
        end
    endtask

    task automatic start_poll();
        int k;
        poll = 1'b1;
        @(posedge clk);
        #1 poll = 1'b0;
        check("att_n_after_poll", att_n, 0);
        k = 0;
        while (!gen && k < 50) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("poll_to_gen", k, T_ATT);
    endtask

    task automatic do_frame(input frame_t r, input int n, input int err_byte, input bit hold_test);
        int         k;
        int         nfull;
        logic [7:0] cb;
        bit         att_hi;
        predict(r, n, err_byte >= 0);
        start_poll();
        nfull = (err_byte >= 0) ? err_byte : n;
        for (int b = 0; b < nfull; b++) begin
            send_byte(r[b], 8, cb);
            check($sformatf("cmd_byte%0d", b), cb, exp_cmd(b));
        end
        if (err_byte >= 0) begin
            send_byte(r[err_byte], 4, cb);
            err = 1'b1;
            @(posedge clk);
            #1 err = 1'b0;
            c_clk = 1'b1;
            dat   = 1'b1;
            if (hold_test) begin
                check("att_n_hold", att_n, 1);
                k = 0;
                att_hi = 1'b1;
                while (busy && k < 50) begin
                    poll = (k == 2);
                    @(posedge clk);
                    #1;
                    k++;
                    if (busy && !att_n) att_hi = 1'b0;
                end
                poll = 1'b0;
                check("hold_cycles", k, T_HOLD);
                check("att_n_high_in_hold", att_hi, 1);
                repeat (3) @(posedge clk);
                #1;
                check("poll_in_hold_ignored", busy, 0);
            end
        end else begin
            dat = 1'b1;
            repeat (2) @(posedge clk);
            #1 ready = 1'b1;
            repeat (2) @(posedge clk);
            #1 ready = 1'b0;
        end
        k = 0;
        while (busy && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("frame_idle", busy, 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        frame_t     f;
        logic [7:0] cb;
        int         ty;

        #2 rst_n = 1'b0;
        #2;
        check("rst_att_n", att_n, 1);
        check("rst_cmd", cmd, 1);
        check("rst_gen", gen, 0);
        check("rst_busy", busy, 0);
        check("rst_valid", valid, 0);
        check("rst_bad_frame", bad_frame, 0);
        check("rst_buttons", buttons, 0);
        check("rst_pad_id", pad_id, 0);
        check("rst_analog", analog, 0);
        check("bytes_expected_in_reset", bytes_expected, BE);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("bytes_expected", bytes_expected, BE);

        for (int j = 0; j < 16; j++) f[j] = 8'h00;
        f[0] = 8'hFF; f[1] = 8'h41; f[2] = 8'h5A; f[3] = 8'h7F; f[4] = 8'hFE;
        do_frame(f, 5, -1, 1'b0);

        f[2] = 8'h00; f[3] = 8'h12; f[4] = 8'h34;
        do_frame(f, 5, -1, 1'b0);

        f[2] = 8'h5A;
        do_frame(f, 5, 3, 1'b1);

        // Abort mid-byte 1 with reset while CMD is driving a 0 bit.
        f[0] = 8'hFF; f[1] = 8'h73; f[2] = 8'h5A; f[3] = 8'h01; f[4] = 8'h02;
        do_frame(f, BE, -1, 1'b0);
        start_poll();
        send_byte(8'hFF, 8, cb);
        c_clk = 1'b0;
        dat   = 1'b1;
        repeat (HALF) @(posedge clk);
        #1;
        check("cmd_before_reset", cmd, 0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_att_n", att_n, 1);
        check("mid_rst_cmd", cmd, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_buttons", buttons, 0);
        check("mid_rst_pad_id", pad_id, 0);
        check("mid_rst_valid", valid, 0);
        c_clk = 1'b1;
        m_b  = '0;
        m_id = '0;
        m_an = '0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        f[0] = 8'hFF; f[1] = 8'h41; f[2] = 8'h5A; f[3] = 8'hFF; f[4] = 8'h7E;
        do_frame(f, 5, -1, 1'b0);

        f[0] = 8'hFF; f[1] = 8'h73; f[2] = 8'h5A; f[3] = 8'hFF; f[4] = 8'hFF;
        f[5] = 8'h80; f[6] = 8'h7F; f[7] = 8'h10; f[8] = 8'hEF;
        do_frame(f, 9, -1, 1'b0);

        for (int t = 0; t < 16; t++) begin
            for (int j = 0; j < 16; j++) f[j] = 8'($urandom);
            ty = $urandom_range(4, 0);
            case (ty)
                0: begin
                    f[2] = 8'h5A;
                    do_frame(f, BE, -1, 1'b0);
                end
                1: begin
                    if (f[2] == 8'h5A) f[2] = 8'hA5;
                    do_frame(f, BE, -1, 1'b0);
                end
                2: begin
                    f[2] = 8'h5A;
                    do_frame(f, $urandom_range(BE - 1, 1), -1, 1'b0);
                end
                3: begin
                    f[2] = 8'h5A;
                    do_frame(f, BE, $urandom_range(BE - 1, 0), 1'b0);
                end
                default: begin
                    f[2] = 8'h5A;
                    do_frame(f, 9, -1, 1'b0);
                end
            endcase
        end

        repeat (10) @(posedge clk);
        #1;
        check("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
